// File: rtl/cb_crc_attach_if.sv
// Payload-in / block-out bus of cb_crc_attach.
// When SOP_RESYNC_EN is defined the bus also carries err_resync.
interface cb_crc_attach_if;
  logic       in_valid;
  logic       in_sop;
  logic       in_size;
  logic [7:0] in_data;
  logic       in_ready;
  logic       blk_ready;
  logic       blk_empty;
  logic       blk_data_rdreq;
  logic [7:0] blk_data;
  logic [7:0] tail_byte;
  logic       code_block_length;
`ifdef SOP_RESYNC_EN
  logic       err_resync;
`endif

  modport slave (
    input  in_valid, in_sop, in_size, in_data, blk_data_rdreq,
    output in_ready, blk_ready, blk_empty, blk_data, tail_byte, code_block_length
`ifdef SOP_RESYNC_EN
    , output err_resync
`endif
  );

  modport master (
    output in_valid, in_sop, in_size, in_data, blk_data_rdreq,
    input  in_ready, blk_ready, blk_empty, blk_data, tail_byte, code_block_length
`ifdef SOP_RESYNC_EN
    , input err_resync
`endif
  );
endinterface

// File: rtl/cb_crc_attach.sv
// Buffers one LTE code block, appends CRC-24A and serves it through a non-showahead read port.
// Optional SOP_RESYNC_EN: a sop seen mid-block restarts the block and pulses err_resync.
module cb_crc_attach #(
  parameter int          ADDR_W      = 10,
  parameter logic [23:0] CRC_POLY    = 24'h864CFB,
  parameter int          SIZE0_BYTES = 132,
  parameter int          SIZE1_BYTES = 768
) (
  input  logic            clk,
  input  logic            reset,
  cb_crc_attach_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, LOAD, APPEND, READY} state_t;

  localparam logic [ADDR_W-1:0] LAST0  = ADDR_W'(SIZE0_BYTES - 1);
  localparam logic [ADDR_W-1:0] LAST1  = ADDR_W'(SIZE1_BYTES - 1);
  localparam logic [ADDR_W-1:0] PLAST0 = ADDR_W'(SIZE0_BYTES - 4);
  localparam logic [ADDR_W-1:0] PLAST1 = ADDR_W'(SIZE1_BYTES - 4);

  // Eight MSB-first LFSR steps of CRC-24A, no reflection
  function automatic logic [23:0] crc_byte(input logic [23:0] c, input logic [7:0] d);
    logic [23:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      if (r[23] ^ d[i]) r = {r[22:0], 1'b0} ^ CRC_POLY;
      else              r = {r[22:0], 1'b0};
    end
    return r;
  endfunction

  state_t            state, state_nx;
  logic [7:0]        mem [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0] wr_cnt, rd_cnt;
  logic [23:0]       crc;
  logic              size_q;
  logic [ADDR_W-1:0] blk_last, pay_last;
  logic              accept, sop_start, resync, load_wr, rd_fire;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;

  assign blk_last  = size_q ? LAST1  : LAST0;
  assign pay_last  = size_q ? PLAST1 : PLAST0;
  assign accept    = bus.in_valid & bus.in_ready;
  assign sop_start = accept & bus.in_sop & (state == IDLE);
`ifdef SOP_RESYNC_EN
  assign resync    = accept & bus.in_sop & (state == LOAD);
`else
  assign resync    = 1'b0;
`endif
  assign load_wr   = accept & (state == LOAD) & ~resync;
  assign rd_fire   = (state == READY) & bus.blk_data_rdreq;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (sop_start) state_nx = LOAD;
      LOAD:    if (load_wr && wr_cnt == pay_last) state_nx = APPEND;
      APPEND:  if (wr_cnt == blk_last) state_nx = READY;
      READY:   if (rd_fire && rd_cnt == blk_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == IDLE) || (state == LOAD);
    bus.blk_ready = (state == READY);
    bus.blk_empty = (state != READY);
  end

  // Single buffer write port: payload bytes, then the three CRC bytes high-first
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = wr_cnt;
    wr_data = bus.in_data;
    if (sop_start || resync) begin
      wr_en   = 1'b1;
      wr_addr = '0;
    end else if (load_wr) begin
      wr_en   = 1'b1;
    end else if (state == APPEND) begin
      wr_en = 1'b1;
      if (wr_cnt == blk_last)               wr_data = crc[7:0];
      else if (wr_cnt == blk_last - 1'b1)   wr_data = crc[15:8];
      else                                  wr_data = crc[23:16];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_cnt                <= '0;
      rd_cnt                <= '0;
      crc                   <= '0;
      size_q                <= 1'b0;
      bus.blk_data          <= '0;
      bus.tail_byte         <= '0;
      bus.code_block_length <= 1'b0;
    end else begin
      if (sop_start || resync) begin
        wr_cnt <= ADDR_W'(1);
        rd_cnt <= '0;
        crc    <= crc_byte(24'd0, bus.in_data);
        size_q <= bus.in_size;
      end else if (load_wr) begin
        wr_cnt <= wr_cnt + 1'b1;
        crc    <= crc_byte(crc, bus.in_data);
      end else if (state == APPEND) begin
        if (wr_cnt == blk_last) begin
          bus.tail_byte         <= crc[7:0];
          bus.code_block_length <= size_q;
        end else begin
          wr_cnt <= wr_cnt + 1'b1;
        end
      end else if (rd_fire) begin
        bus.blk_data <= mem[rd_cnt];
        if (rd_cnt == blk_last) begin
          rd_cnt <= '0;
          wr_cnt <= '0;
          crc    <= '0;
        end else begin
          rd_cnt <= rd_cnt + 1'b1;
        end
      end
    end
  end

`ifdef SOP_RESYNC_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) bus.err_resync <= 1'b0;
    else       bus.err_resync <= resync;
  end
`endif

endmodule
